// File: rtl/control_sequencer.sv
// control_sequencer
// Hardwired control unit for a simple load/store CPU. A ten-state machine
// walks every instruction through fetch (T0-T2) and an opcode-dependent
// execute phase (T3-T7). The datapath strobes, memory commands, register
// select lines and alu_op are decoded combinationally from the current
// state and the opcode held in ir[31:27].
//
// Ports
//   clock      : system clock, rising edge active
//   reset      : asynchronous active-high reset, forces the RST state
//   ir         : instruction register contents, opcode in ir[31:27]
//   mem_ready  : memory completion strobe for Read/Write waits
//   stop       : halt request, honoured only when returning to T0
//   PCout..Cout: datapath bus/load strobes
//   Read/Write : memory commands
//   Gra..BAout : register select / encode controls
//   alu_op     : ALU operation code
//   run        : high while the sequencer is executing instructions
module control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        run
);

    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_T7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    // Address calculation for ldi/ld/st reuses the ALU adder.
    localparam logic [4:0] OP_ADD = 5'b00011;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [4:0] opcode;
    logic       is_rr;
    logic       is_imm;
    logic       is_ldi;
    logic       is_ld;
    logic       is_st;
    logic       is_jr;
    logic       is_halt;
    logic       uses_alu;
    logic [3:0] t0_or_halt;
    logic       ir_unused;

    assign opcode    = ir[31:27];
    assign ir_unused = ^ir[26:0];

    // Opcode classes; anything outside these classes executes as a nop.
    always_comb begin
        is_rr    = (opcode >= 5'b00011) && (opcode <= 5'b01000);
        is_imm   = (opcode >= 5'b01100) && (opcode <= 5'b01110);
        is_ldi   = (opcode == 5'b00001);
        is_ld    = (opcode == 5'b00000);
        is_st    = (opcode == 5'b00010);
        is_jr    = (opcode == 5'b10100);
        is_halt  = (opcode == 5'b11011);
        uses_alu = is_rr || is_imm || is_ldi || is_ld || is_st;
    end

    // A pending stop request diverts every return to T0 into HALT, so the
    // machine only ever halts on an instruction boundary.
    assign t0_or_halt = stop ? ST_HALT : ST_T0;

    // Next-state logic; the memory waits in T1/T6/T7 are the only places
    // mem_ready is consulted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = t0_or_halt;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (mem_ready) state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                if (is_halt)       state_d = ST_HALT;
                else if (uses_alu) state_d = ST_T4;
                else               state_d = t0_or_halt;
            end
            ST_T4:   state_d = ST_T5;
            ST_T5: begin
                if (is_ld || is_st) state_d = ST_T6;
                else                state_d = t0_or_halt;
            end
            ST_T6: begin
                if (is_ld) begin
                    if (mem_ready) state_d = ST_T7;
                end else if (is_st) begin
                    state_d = ST_T7;
                end else begin
                    state_d = t0_or_halt;
                end
            end
            ST_T7: begin
                if (is_st) begin
                    if (mem_ready) state_d = t0_or_halt;
                end else begin
                    state_d = t0_or_halt;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_RST;
        else       state_q <= state_d;
    end

    // Output decode: every strobe defaults low and only the states that
    // need a strobe raise it, so RST and HALT drive all zeros.
    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        alu_op  = 5'b00000;
        run     = (state_q != ST_RST) && (state_q != ST_HALT);
        case (state_q)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (is_rr || is_imm) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_ldi || is_ld || is_st) begin
                    // BAout makes R0 read as zero for base+offset addressing.
                    Grb   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (is_jr) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end
            end
            ST_T4: begin
                if (is_rr) begin
                    Grc    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = opcode;
                end else if (is_imm) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = opcode;
                end else if (is_ldi || is_ld || is_st) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = OP_ADD;
                end
            end
            ST_T5: begin
                if (is_ld || is_st) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end else if (is_rr || is_imm || is_ldi) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (is_st) begin
                    Gra   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
